// File: rtl/alu_share_if.sv
// Bundle of the two requester channels, the two response channels, the shared
// ALU hookup and the status outputs of alu_share_arbiter.
// slave  : the arbiter side.
// master : the clients plus the ALU, i.e. everything around the arbiter.
interface alu_share_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;

  logic [DATA_W-1:0] alu_src_a;
  logic [DATA_W-1:0] alu_src_b;
  logic [OP_W-1:0]   alu_operation;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    output alu_src_a, alu_src_b, alu_operation,
    output busy, grant_id
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_src_a, alu_src_b, alu_operation,
    input  busy, grant_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters.
// Round-robin pick in IDLE, operands held on the ALU for SETTLE_CYCLES in EXEC,
// result/zero captured and returned to the winner in RESP with valid/ready.
module alu_share_arbiter #(
  parameter int DATA_W        = 4,
  parameter int OP_W          = 3,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input logic        clk,
  input logic        rst_n,
  alu_share_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic              ptr_q;        // requester that wins a tie
  logic              grant_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] src_a_q, src_b_q, res_q;
  logic [OP_W-1:0]   op_q;
  logic              zero_q;

  logic              win;
  logic              accept;
  logic              capture;
  logic              handshake;
  logic              ready0, ready1;

  // Next-state logic, winner selection and the one-cycle strobes of the datapath.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    win       = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A tie goes to the pointer; otherwise whoever is asking wins.
        if (bus.req0_valid && bus.req1_valid) win = ptr_q;
        else                                  win = bus.req1_valid;
        accept = bus.req0_valid || bus.req1_valid;
        ready0 = accept && !win;
        ready1 = accept &&  win;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        handshake = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus operand latch, settle counter, result capture and pointer.
  // NOTE: reset is synchronous and clears every register, including the datapath copies,
  // because all outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= 4'd0;
      src_a_q <= '0;
      src_b_q <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      if (accept) begin
        grant_q <= win;
        cnt_q   <= CNT_INIT;
        op_q    <= win ? bus.req1_op : bus.req0_op;
        src_a_q <= win ? bus.req1_a  : bus.req0_a;
        src_b_q <= win ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (capture) begin
        res_q  <= bus.alu_result;
        zero_q <= bus.alu_zero;
      end
      // Priority passes to the other requester only once a response completes.
      if (handshake) ptr_q <= ~grant_q;
    end
  end

  logic rsp0_v, rsp1_v;
  assign rsp0_v = (state_q == RESP) && !grant_q;
  assign rsp1_v = (state_q == RESP) &&  grant_q;

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.rsp0_valid    = rsp0_v;
  assign bus.rsp1_valid    = rsp1_v;
  assign bus.rsp0_result   = rsp0_v ? res_q : '0;
  assign bus.rsp1_result   = rsp1_v ? res_q : '0;
  assign bus.rsp0_zero     = rsp0_v & zero_q;
  assign bus.rsp1_zero     = rsp1_v & zero_q;
  assign bus.alu_src_a     = src_a_q;
  assign bus.alu_src_b     = src_b_q;
  assign bus.alu_operation = op_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.grant_id      = grant_q;

endmodule
